fpu_wb_stage: RTL and testbench
===============================

# fpu_wb_stage

Writeback stage directly downstream of the single-cycle FP execute block. Accepts one execute result per handshake, formats it for the integer or FP register file, and buffers up to two results in a FIFO. Maintains the sticky `fflags` accrued-exception register, which is updated when a result retires to the register file. Supports CSR access to `fflags` and a pipeline flush.

## Interface

**Parameters**
- `XLEN`, 64: integer register and write-data width.
- `FLEN`, 32: FP result width (`EXPWIDTH + SIGWIDTH`).

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute result present.
- `in_ready` out 1: stage can accept a result.
- `in_ftype` in 5: op code of the result (0–21, execute encoding).
- `in_rd` in 5: destination register index.
- `in_farith` in FLEN: FP arithmetic, convert-to-float, or sign-inject result.
- `in_wconv` in 32: 32-bit float-to-int result.
- `in_lconv` in 64: 64-bit float-to-int result.
- `in_fcmp` in 1: compare result.
- `in_fclass` in XLEN: classify mask.
- `in_flags` in 5: exception flags {NV,DZ,OF,UF,NX}.
- `flush` in 1: discard all buffered results.
- `wb_valid` out 1: head result valid.
- `wb_ready` in 1: register file accepts the head result.
- `wb_is_fp` out 1: 1 = FP register file, 0 = integer register file.
- `wb_rd` out 5: destination index.
- `wb_data` out XLEN: formatted write data.
- `csr_fflags_we` in 1: CSR write strobe.
- `csr_fflags_wdata` in 5: CSR write value.
- `fflags` out 5: accrued exception flags.

## Operation

- **Input handshake.** A push occurs when `in_valid & in_ready`. Each entry stores {is_fp, rd, data[XLEN], flags[5]}, formatted at push time.
- **Destination routing.**
  - ftype 0–8 and 13–17 go to the FP register file.
  - ftype 9–12 and 18–21 go to the integer register file.
  - Codes 22–31 go to the integer register file with rd forced to 0, data 0, and flags 0.
- **Data formatting.**
  - FP destination: `{(XLEN-FLEN){1'b0}, in_farith}`.
  - ftype 9 and 10: `in_wconv` sign-extended from bit 31. Ops 9 and 10 both sign-extend.
  - ftype 11 and 12: `in_lconv`.
  - ftype 18–20: `{(XLEN-1){0}, in_fcmp}`.
  - ftype 21: `in_fclass`.
- **FIFO.** Two entries, strict order, 2-bit occupancy `count`.
  - `in_ready = (count != 2)`. It is registered-state based and does not depend on `wb_ready`.
  - `wb_valid = (count != 0)`. All `wb_*` outputs come from the head entry.
  - A pop occurs when `wb_valid & wb_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Read and write pointers are 1 bit and wrap modulo 2.
- **fflags update.** Next value:
  - base = `csr_fflags_we ? csr_fflags_wdata : fflags`
  - `fflags_next = base | (pop ? head.flags : 5'b0)`
  - A CSR write and a retirement in the same cycle therefore keep both contributions.
  - Flags of flushed or never-retired entries are never accrued.
- **Flush.** `count` and both pointers clear next cycle. Push and pop in the flush cycle are ignored. A pop coincident with flush still counts as retired for `fflags` only if `flush` is low; with flush high, no flags are accrued. `fflags` otherwise keeps its value, and the CSR write still applies.
- **Reset.** Clears `count`, pointers, and `fflags` to 0.
  - Post-reset outputs: `in_ready=1`, `wb_valid=0`, `wb_is_fp=0`, `wb_rd=0`, `wb_data=0`, `fflags=0`.
  - Entry storage also clears, so head outputs read 0.
  - Reset mid-operation discards buffered results.

## Timing

- Latency: a push in cycle N gives `wb_valid=1` in cycle N+1 with that result at the head, if the FIFO was empty.
- Throughput: one result per cycle when `wb_ready` is held high.
- Back-pressure: with `wb_ready` low, two pushes fill the FIFO and `in_ready` falls in the cycle after the second push.
- `fflags` updates in the cycle after the pop or CSR write.
- All outputs are registers or mux-of-registers. There is no combinational path from `in_*` to `wb_*`.

## Configuration

- `FPU_WB_CANON_NAN_EN`
  - **Defined:** for ftype 0–8, 13, and 14 with an FP result whose exponent is all ones and mantissa is non-zero, the stored FP data is replaced by the canonical NaN. For FLEN=32 this is 0x7FC00000. Sign-inject ops (15–17) are never altered. Flags are unchanged.
  - **Undefined:** the FP result passes through bit-exact.

## Test plan

- **Integer sign-extend and latency.** Push ftype 10, `in_wconv`=0x80000001, rd=5, with `wb_ready`=1. Next cycle: `wb_valid`=1, `wb_is_fp`=0, `wb_rd`=5, `wb_data`=0xFFFFFFFF80000001. The following cycle: `wb_valid`=0.
- **Back-pressure.** With `wb_ready`=0, push ftype 0 (0x3F800000, rd=1), then ftype 2 (0x40000000, rd=2). `in_ready`=0 after the second push. Raise `wb_ready`: retires 0x3F800000 then 0x40000000 in order, and `in_ready` returns to 1.
- **Flag accrual with CSR write.** Retire an entry with flags 0x01 in the same cycle as a CSR write of 0x10 → `fflags`=0x11. Retire flags 0x04 → `fflags`=0x15.
- **Flush.** Hold 2 entries with flags 0x10, assert `flush` → `wb_valid`=0 and `in_ready`=1 next cycle, and `fflags` is unchanged.
- **Canonical NaN.** Push ftype 0 with `in_farith`=0xFFC00123. With the macro defined, `wb_data`=0x7FC00000; without it, 0xFFC00123. Push ftype 16 with 0xFFC00123 → 0xFFC00123 in both builds.
- **Reset mid-operation.** With 1 entry held, assert `rst` for 1 cycle → all outputs at reset values, `in_ready`=1, `fflags`=0.

Source files
------------

// File: rtl/fpu_wb_stage.sv
// Writeback stage after the FP execute block: formats results, buffers two, accrues fflags.
// Optional build macro FPU_WB_CANON_NAN_EN replaces arithmetic NaN results with the canonical NaN.
module fpu_wb_stage #(
  parameter int XLEN = 64,
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_ftype,
  input  logic [4:0]      in_rd,
  input  logic [FLEN-1:0] in_farith,
  input  logic [31:0]     in_wconv,
  input  logic [63:0]     in_lconv,
  input  logic            in_fcmp,
  input  logic [XLEN-1:0] in_fclass,
  input  logic [4:0]      in_flags,
  input  logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_is_fp,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            csr_fflags_we,
  input  logic [4:0]      csr_fflags_wdata,
  output logic [4:0]      fflags
);

`ifdef FPU_WB_CANON_NAN_EN
  localparam int EXPW = (FLEN == 64) ? 11 : (FLEN == 16) ? 5 : 8;
  localparam int MANW = FLEN - EXPW - 1;
  localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
`endif

  logic            r_is_fp [2];
  logic [4:0]      r_rd    [2];
  logic [XLEN-1:0] r_data  [2];
  logic [4:0]      r_flags [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic [4:0]      r_fflags;

  logic            w_push;
  logic            w_pop;
  logic            w_is_fp;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic [4:0]      w_flags;
  logic [FLEN-1:0] w_fp_data;

  assign in_ready = (r_count != 2'd2);
  assign wb_valid = (r_count != 2'd0);
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = wb_valid & wb_ready & ~flush;

  assign wb_is_fp = r_is_fp[r_rptr];
  assign wb_rd    = r_rd[r_rptr];
  assign wb_data  = r_data[r_rptr];
  assign fflags   = r_fflags;

  always_comb begin
    w_fp_data = in_farith;
`ifdef FPU_WB_CANON_NAN_EN
    // Sign-inject ops (15-17) move the payload untouched, so only 0-14 are canonicalised.
    if (in_ftype <= 5'd14 && (&in_farith[FLEN-2 -: EXPW]) && (|in_farith[MANW-1:0]))
      w_fp_data = CANON_NAN;
`endif
  end

  always_comb begin
    w_is_fp = 1'b0;
    w_rd    = in_rd;
    w_data  = '0;
    w_flags = in_flags;
    if (in_ftype <= 5'd8 || (in_ftype >= 5'd13 && in_ftype <= 5'd17)) begin
      w_is_fp = 1'b1;
      w_data  = XLEN'(w_fp_data);
    end else if (in_ftype <= 5'd10) begin
      w_data = XLEN'($signed(in_wconv));
    end else if (in_ftype <= 5'd12) begin
      w_data = XLEN'(in_lconv);
    end else if (in_ftype <= 5'd20) begin
      w_data = XLEN'(in_fcmp);
    end else if (in_ftype == 5'd21) begin
      w_data = in_fclass;
    end else begin
      w_rd    = 5'd0;
      w_flags = 5'd0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_is_fp[gi] <= 1'b0;
          r_rd[gi]    <= 5'd0;
          r_data[gi]  <= '0;
          r_flags[gi] <= 5'd0;
        end else if (w_push && r_wptr == 1'(gi)) begin
          r_is_fp[gi] <= w_is_fp;
          r_rd[gi]    <= w_rd;
          r_data[gi]  <= w_data;
          r_flags[gi] <= w_flags;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_fflags <= 5'd0;
    end else begin
      // A CSR write and a retirement in the same cycle both contribute.
      r_fflags <= (csr_fflags_we ? csr_fflags_wdata : r_fflags) |
                  (w_pop ? r_flags[r_rptr] : 5'd0);
      if (flush) begin
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= ~r_wptr;
        if (w_pop)  r_rptr <= ~r_rptr;
        if (w_push && !w_pop)      r_count <= r_count + 2'd1;
        else if (w_pop && !w_push) r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Bench for fpu_wb_stage: directed scenarios plus random traffic against a queue-based model.
module tb_fpu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ftype;
  logic [4:0]  in_rd;
  logic [31:0] in_farith;
  logic [31:0] in_wconv;
  logic [63:0] in_lconv;
  logic        in_fcmp;
  logic [63:0] in_fclass;
  logic [4:0]  in_flags;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_is_fp;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        csr_fflags_we;
  logic [4:0]  csr_fflags_wdata;
  logic [4:0]  fflags;

  fpu_wb_stage #(.XLEN(64), .FLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ftype(in_ftype), .in_rd(in_rd),
    .in_farith(in_farith), .in_wconv(in_wconv), .in_lconv(in_lconv), .in_fcmp(in_fcmp),
    .in_fclass(in_fclass), .in_flags(in_flags), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_fp(wb_is_fp), .wb_rd(wb_rd),
    .wb_data(wb_data), .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
    .fflags(fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_fp;
    bit [4:0]  rd;
    bit [63:0] data;
    bit [4:0]  flags;
  } ent_t;

  ent_t     q[$];
  bit [4:0] m_fflags;
  bit       m_zero;
  int       n_pass  = 0;
  int       n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected entry straight from the op-code table.
  function automatic ent_t fmt();
    ent_t e;
    int   t = int'(in_ftype);
    e.is_fp = 0; e.rd = in_rd; e.data = 0; e.flags = in_flags;
    if (t <= 8 || (t >= 13 && t <= 17)) begin
      e.is_fp = 1;
      e.data  = {32'd0, in_farith};
`ifdef FPU_WB_CANON_NAN_EN
      if (t <= 14 && ((in_farith >> 23) & 32'hFF) == 32'hFF && (in_farith & 32'h7FFFFF) != 0)
        e.data = 64'h7FC0_0000;
`endif
    end else if (t == 9 || t == 10) begin
      e.data = (in_wconv >= 32'h8000_0000) ? (64'hFFFF_FFFF_0000_0000 + in_wconv) : {32'd0, in_wconv};
    end else if (t == 11 || t == 12) begin
      e.data = in_lconv;
    end else if (t >= 18 && t <= 20) begin
      e.data = in_fcmp ? 64'd1 : 64'd0;
    end else if (t == 21) begin
      e.data = in_fclass;
    end else begin
      e.rd = 0; e.flags = 0;
    end
    return e;
  endfunction

  task automatic check_model();
    chk("in_ready", in_ready, q.size() < 2);
    chk("wb_valid", wb_valid, q.size() != 0);
    chk("fflags", fflags, m_fflags);
    if (q.size() != 0) begin
      chk("wb_is_fp", wb_is_fp, q[0].is_fp);
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].data);
    end else if (m_zero) begin
      chk("rst_is_fp", wb_is_fp, 0);
      chk("rst_rd", wb_rd, 0);
      chk("rst_data", wb_data, 0);
    end
  endtask

  // Advance the model by the inputs currently driven, then clock and compare.
  task automatic tick();
    bit push, pop;
    if (rst) begin
      q.delete(); m_fflags = 0; m_zero = 1;
    end else begin
      push = in_valid && q.size() < 2 && !flush;
      pop  = wb_ready && q.size() != 0 && !flush;
      m_fflags = (csr_fflags_we ? csr_fflags_wdata : m_fflags) | (pop ? q[0].flags : 5'd0);
      if (flush) q.delete();
      else begin
        if (pop) q.delete(0);
        if (push) begin q.push_back(fmt()); m_zero = 0; end
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic rdy);
    rst = 0; in_valid = 0; flush = 0; csr_fflags_we = 0; wb_ready = rdy;
  endtask

  task automatic put(input logic [4:0] t, input logic [4:0] rd, input logic [31:0] fa,
                     input logic [4:0] fl);
    in_valid = 1; in_ftype = t; in_rd = rd; in_farith = fa; in_flags = fl;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_ftype = 0; in_rd = 0; in_farith = 0; in_wconv = 0;
    in_lconv = 0; in_fcmp = 0; in_fclass = 0; in_flags = 0; flush = 0; wb_ready = 0;
    csr_fflags_we = 0; csr_fflags_wdata = 0;
    tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_fflags", fflags, 0);

    // Sign extension and one-cycle latency
    idle(1); put(5'd10, 5'd5, 32'h0, 5'd0); in_wconv = 32'h8000_0001;
    tick();
    chk("sext_valid", wb_valid, 1);
    chk("sext_data", wb_data, 64'hFFFF_FFFF_8000_0001);
    chk("sext_rd", wb_rd, 5);
    idle(1); tick();
    chk("sext_drain", wb_valid, 0);

    // Back-pressure and ordering
    idle(0); put(5'd0, 5'd1, 32'h3F80_0000, 5'h01); tick();
    idle(0); put(5'd2, 5'd2, 32'h4000_0000, 5'h04); tick();
    chk("bp_full", in_ready, 0);
    chk("bp_head", wb_data, 64'h3F80_0000);
    // Retire flags 0x01 together with CSR write 0x10
    idle(1); csr_fflags_we = 1; csr_fflags_wdata = 5'h10; tick();
    chk("csr_accrue", fflags, 5'h11);
    chk("bp_second", wb_data, 64'h4000_0000);
    chk("bp_ready", in_ready, 1);
    idle(1); tick();
    chk("accrue2", fflags, 5'h15);

    // Flush discards entries without accruing
    idle(0); put(5'd1, 5'd3, 32'h1, 5'h10); tick();
    idle(0); put(5'd1, 5'd4, 32'h2, 5'h10); tick();
    idle(1); flush = 1; tick();
    chk("flush_valid", wb_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_fflags", fflags, 5'h15);

    // Canonical NaN vs sign-inject
    idle(0); put(5'd0, 5'd6, 32'hFFC0_0123, 5'd0); tick();
`ifdef FPU_WB_CANON_NAN_EN
    chk("nan_arith", wb_data, 64'h7FC0_0000);
`else
    chk("nan_arith", wb_data, 64'hFFC0_0123);
`endif
    idle(1); tick();
    idle(0); put(5'd16, 5'd7, 32'hFFC0_0123, 5'd0); tick();
    chk("nan_sgnj", wb_data, 64'hFFC0_0123);

    // Reset with one entry held
    idle(0); rst = 1; tick();
    chk("mid_rst_valid", wb_valid, 0);
    chk("mid_rst_data", wb_data, 0);
    chk("mid_rst_fflags", fflags, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      in_valid         = ($urandom_range(0, 3) != 0);
      in_ftype         = 5'($urandom_range(0, 31));
      in_rd            = 5'($urandom);
      in_farith        = $urandom;
      if ($urandom_range(0, 3) == 0) in_farith[30:23] = 8'hFF;
      in_wconv         = $urandom;
      in_lconv         = {$urandom, $urandom};
      in_fcmp          = 1'($urandom);
      in_fclass        = {$urandom, $urandom};
      in_flags         = 5'($urandom);
      flush            = ($urandom_range(0, 29) == 0);
      wb_ready         = ($urandom_range(0, 2) != 0);
      csr_fflags_we    = ($urandom_range(0, 14) == 0);
      csr_fflags_wdata = 5'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
